// File: rtl/fifo_read_ctrl.sv
// Read-side controller for a registered-output FIFO: credit-based prefetch into a 2-entry skid
// buffer. Optional delivered-word counter enabled by macro FIFO_READ_CTRL_WCNT_EN.
module fifo_read_ctrl #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           word_count
);

    logic [DATA_WIDTH-1:0] r_buf [2];
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [1:0]            r_occ;
    logic                  r_infl;

    logic                  w_pop;
    logic [2:0]            w_credit;

    assign out_valid = (r_occ != 2'd0);
    assign out_data  = r_buf[r_rd_ptr];
    assign w_pop     = out_valid & out_ready;

    // Words owned after this cycle: buffered plus arriving minus leaving; never more than two.
    assign w_credit   = {1'b0, r_occ} + {2'b00, r_infl} - {2'b00, w_pop};
    assign fifo_rd_en = rst & ~fifo_empty & (w_credit < 3'd2);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_occ    <= 2'd0;
            r_infl   <= 1'b0;
        end else begin
            if (r_infl) begin
                r_buf[r_wr_ptr] <= fifo_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ  <= r_occ + {1'b0, r_infl} - {1'b0, w_pop};
            r_infl <= fifo_rd_en;
        end
    end

`ifdef FIFO_READ_CTRL_WCNT_EN
    logic [15:0] r_wcnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wcnt <= 16'd0;
        end else if (w_pop) begin
            r_wcnt <= r_wcnt + 16'd1;
        end
    end

    assign word_count = r_wcnt;
`else
    assign word_count = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: upstream FIFO emulated with a queue, expected
// behaviour from a scoreboard of issued reads (each tagged with its issue cycle).
module tb_fifo_read_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_rd_en;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] word_count;

    fifo_read_ctrl #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic [7:0] d;
    } ent_t;

    logic [7:0]  src_q[$];
    ent_t        sb[$];
    int          n = 0;
    int          checks = 0;
    int          errors = 0;
    bit          arr_v = 1'b0;
    logic [7:0]  arr_d = 8'h00;
    int          wc_model = 0;
    bit          cur_rst;
    bit          exp_valid;
    bit          exp_pop;
    bit          exp_rd;
    logic [7:0]  exp_data;
    logic [15:0] exp_wc;

    // Apply inputs for one cycle and compute what the outputs must be from the scoreboard.
    task automatic drive(input bit rdy, input bit rst_v);
        @(negedge clk);
        rst        = rst_v;
        out_ready  = rdy;
        fifo_empty = (src_q.size() == 0);
        fifo_data  = arr_v ? arr_d : 8'($urandom);
        #1;
        exp_valid = (sb.size() > 0) && (sb[0].t <= n - 2);
        exp_data  = exp_valid ? sb[0].d : 8'h00;
        exp_pop   = exp_valid && rdy;
        exp_rd    = rst_v && !fifo_empty && ((sb.size() - (exp_pop ? 1 : 0)) < 2);
`ifdef FIFO_READ_CTRL_WCNT_EN
        exp_wc = 16'(wc_model);
`else
        exp_wc = 16'd0;
`endif
        cur_rst = rst_v;
    endtask

    // Commit the expected transfers to the model and cross the rising edge.
    task automatic advance();
        ent_t e;
        if (!cur_rst) begin
            sb.delete();
            arr_v    = 1'b0;
            wc_model = 0;
        end else begin
            if (exp_pop) begin
                void'(sb.pop_front());
                wc_model = wc_model + 1;
            end
            if (exp_rd) begin
                e.t = n;
                e.d = src_q.pop_front();
                sb.push_back(e);
                arr_v = 1'b1;
                arr_d = e.d;
            end else begin
                arr_v = 1'b0;
            end
        end
        @(posedge clk);
        n++;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0);
        advance();
        drive(1'b0, 1'b0);
        checks++;
        if (fifo_rd_en !== 1'b0) begin
            errors++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en);
        end
        checks++;
        if (out_data !== 8'h00) begin
            errors++; $display("FAIL reset_out_data: got %h want 00", out_data);
        end
        advance();
        for (int i = 0; i < 10; i++) begin
            drive(1'($urandom), 1'b1);
            checks++;
            if (fifo_rd_en !== 1'b0 || out_valid !== 1'b0 || word_count !== 16'd0) begin
                errors++;
                $display("FAIL reset_idle: rd_en=%b valid=%b wc=%h want 0/0/0000",
                         fifo_rd_en, out_valid, word_count);
            end
            advance();
        end
    endtask

    task automatic test_stream();
        int first_rd = -1;
        int first_val = -1;
        int last_val = -1;
        int got = 0;
        for (int i = 1; i <= 16; i++) src_q.push_back(8'(i));
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, 1'b1);
            checks++;
            if (fifo_rd_en !== exp_rd || out_valid !== exp_valid) begin
                errors++;
                $display("FAIL stream_ctrl: rd_en=%b valid=%b want %b/%b",
                         fifo_rd_en, out_valid, exp_rd, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (out_data !== exp_data) begin
                    errors++; $display("FAIL stream_data: got %h want %h", out_data, exp_data);
                end
            end
            if (fifo_rd_en === 1'b1 && first_rd < 0) first_rd = n;
            if (out_valid === 1'b1) begin
                if (first_val < 0) first_val = n;
                last_val = n;
                got++;
            end
            advance();
        end
        checks++;
        if (first_val - first_rd != 2 || last_val - first_val != 15 || got != 16) begin
            errors++;
            $display("FAIL stream_timing: latency=%0d span=%0d words=%0d want 2/15/16",
                     first_val - first_rd, last_val - first_val, got);
        end
        drive(1'b0, 1'b1);
        checks++;
`ifdef FIFO_READ_CTRL_WCNT_EN
        if (word_count !== 16'd16) begin
            errors++; $display("FAIL stream_wcnt: got %0d want 16", word_count);
        end
`else
        if (word_count !== 16'd0) begin
            errors++; $display("FAIL stream_wcnt: got %0d want 0", word_count);
        end
`endif
        advance();
    endtask

    task automatic test_backpressure();
        int reads = 0;
        logic [7:0] seen[$];
        src_q.push_back(8'hA5);
        src_q.push_back(8'h5A);
        src_q.push_back(8'h3C);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1);
            checks++;
            if (fifo_rd_en !== exp_rd || out_valid !== exp_valid) begin
                errors++;
                $display("FAIL bp_hold_ctrl: rd_en=%b valid=%b want %b/%b",
                         fifo_rd_en, out_valid, exp_rd, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (out_data !== 8'hA5) begin
                    errors++; $display("FAIL bp_hold_data: got %h want a5", out_data);
                end
            end
            if (fifo_rd_en === 1'b1) reads++;
            advance();
        end
        checks++;
        if (reads != 2) begin
            errors++; $display("FAIL bp_reads_stalled: got %0d want 2", reads);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1);
            checks++;
            if (fifo_rd_en !== exp_rd || out_valid !== exp_valid) begin
                errors++;
                $display("FAIL bp_drain_ctrl: rd_en=%b valid=%b want %b/%b",
                         fifo_rd_en, out_valid, exp_rd, exp_valid);
            end
            if (fifo_rd_en === 1'b1) reads++;
            if (out_valid === 1'b1) seen.push_back(out_data);
            advance();
        end
        checks++;
        if (reads != 3 || seen.size() != 3) begin
            errors++; $display("FAIL bp_counts: reads=%0d words=%0d want 3/3", reads, seen.size());
        end else begin
            checks++;
            if (seen[0] !== 8'hA5 || seen[1] !== 8'h5A || seen[2] !== 8'h3C) begin
                errors++;
                $display("FAIL bp_order: got %h %h %h want a5 5a 3c", seen[0], seen[1], seen[2]);
            end
        end
    endtask

    task automatic test_toggle();
        int prev = -1;
        int got = 0;
        for (int i = 0; i < 40; i++) src_q.push_back(8'(i));
        for (int i = 0; i < 100 && got < 40; i++) begin
            drive(1'(i % 2 == 0), 1'b1);
            checks++;
            if (fifo_rd_en !== exp_rd || out_valid !== exp_valid) begin
                errors++;
                $display("FAIL toggle_ctrl: rd_en=%b valid=%b want %b/%b",
                         fifo_rd_en, out_valid, exp_rd, exp_valid);
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (int'(out_data) != prev + 1) begin
                    errors++; $display("FAIL toggle_seq: got %0d want %0d", out_data, prev + 1);
                end
                prev = int'(out_data);
                got++;
            end
            advance();
        end
        checks++;
        if (got != 40) begin
            errors++; $display("FAIL toggle_count: got %0d want 40", got);
        end
    endtask

    task automatic test_midreset();
        logic [7:0] resume;
        int first = -1;
        for (int i = 0; i < 10; i++) src_q.push_back(8'(8'h10 + i));
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1);
            advance();
        end
        drive(1'b1, 1'b1);
        checks++;
        if (fifo_rd_en !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL midrst_setup: rd_en=%b valid=%b want 1/1", fifo_rd_en, out_valid);
        end
        advance();
        resume = src_q[0];
        drive(1'b1, 1'b0);
        checks++;
        if (fifo_rd_en !== 1'b0) begin
            errors++; $display("FAIL midrst_rd_en: got %b want 0", fifo_rd_en);
        end
        advance();
        drive(1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_flush: valid=%b want 0", out_valid);
        end
        advance();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1);
            if (out_valid === 1'b1 && first < 0) first = int'(out_data);
            advance();
        end
        checks++;
        if (first != int'(resume)) begin
            errors++; $display("FAIL midrst_resume: got %0d want %0d", first, resume);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0 && src_q.size() < 6) src_q.push_back(8'($urandom));
            drive(1'($urandom_range(0, 2) != 0), 1'b1);
            checks++;
            if (fifo_rd_en !== exp_rd || out_valid !== exp_valid || word_count !== exp_wc) begin
                errors++;
                $display("FAIL random_ctrl: rd_en=%b valid=%b wc=%h want %b/%b/%h",
                         fifo_rd_en, out_valid, word_count, exp_rd, exp_valid, exp_wc);
            end
            if (exp_valid) begin
                checks++;
                if (out_data !== exp_data) begin
                    errors++; $display("FAIL random_data: got %h want %h", out_data, exp_data);
                end
            end
            advance();
        end
    endtask

`ifdef FIFO_READ_CTRL_WCNT_EN
    task automatic test_wrap();
        int pops = 0;
        drive(1'b0, 1'b0);
        advance();
        while (pops < 65537) begin
            while (src_q.size() < 4) src_q.push_back(8'($urandom));
            drive(1'b1, 1'b1);
            if (exp_pop) pops++;
            advance();
        end
        drive(1'b0, 1'b1);
        checks++;
        if (word_count !== 16'h0001) begin
            errors++; $display("FAIL wcnt_wrap: got %h want 0001", word_count);
        end
        advance();
    endtask
`endif

    initial begin
        rst        = 1'b0;
        out_ready  = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle();
        test_midreset();
        test_random();
`ifdef FIFO_READ_CTRL_WCNT_EN
        test_wrap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
